// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// uart_tx_if -- handshake/serial bundle for the UART transmitter.
//
// Signals:
//   s_tick       baud oversampling tick, one clk wide, 16 per bit period
//   tx_start     one-cycle request to send din (honoured only when idle)
//   din          data byte, sampled in the cycle tx_start is accepted
//   tx_busy      high while a frame is in progress
//   tx_done_tick one-clk pulse as the final stop tick completes
//   tx           registered serial line, idles high
//
// Modports:
//   master  the side that requests frames and watches the line
//   slave   the transmitter itself
// ----------------------------------------------------------------------------
interface uart_tx_if;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    modport master (
        output s_tick, tx_start, din,
        input  tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx_busy, tx_done_tick, tx
    );
endinterface

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx -- UART serial transmitter on a 16x oversampling tick.
//
// Serialises a byte LSB-first as: start bit, DBIT data bits, optional parity
// bit, then a stop period of SB_TICK ticks. Each non-stop bit lasts 16 ticks
// of s_tick, shared with the receiver so both sides use one timebase.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low reset (0 = reset asserted)
//   bus    uart_tx_if.slave: s_tick, tx_start, din in; tx_busy,
//          tx_done_tick, tx out
//
// Parameters:
//   DBIT        data bits per frame, 1..8 (din[DBIT-1:0] is sent)
//   SB_TICK     stop period in ticks: 16 = 1, 24 = 1.5, 32 = 2 stop bits
//   PARITY_ODD  parity sense when parity is built: 0 = even, 1 = odd
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit (XOR of the data bits,
//                      XORed with PARITY_ODD, captured at accept) is sent for
//                      16 ticks between the last data bit and the stop bit.
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } state_e;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);
`else
    // Parity sense has no meaning without the parity state.
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    state_e     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       tx_q, tx_d;
    logic       busy_q;
    logic       done_tick;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A tick arriving with the accept is not counted; the start
                // bit is timed from the next tick.
                if (bus.tx_start) begin
                    b_d     = bus.din;
                    s_d     = 5'd0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^(bus.din & DATA_MASK)) ^ PARITY_ODD;
`endif
                end
            end

            ST_START: begin
                if (bus.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (bus.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = 5'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = 5'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (bus.s_tick) begin
                    if (s_q == STOP_LAST) begin
                        done_tick = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The line is decoded from the next state so the pin flop changes on
        // the same edge as the state register.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = busy_q;
    // The done pulse is asserted while still in stop, so a tx_start in the
    // same cycle is ignored and the earliest restart is the following cycle.
    assign bus.tx_done_tick = done_tick;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two transmitters share one stimulus: instance 0 uses the defaults
// (DBIT 8, SB_TICK 16, even parity) and instance 1 uses DBIT 7, SB_TICK 32,
// odd parity. A frame model tracks, per instance, how many ticks have elapsed
// since accept and derives the expected line level from that count alone.
// Build with +define+UART_TX_PARITY_EN to cover the parity variant.
// ----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN0 = 16 * (1 + 8 + PAR) + 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'd0;
    int         tick_mode = 1;
    int         tcnt = 0;

    int checks = 0;
    int errors = 0;
    int frames0 = 0;

    always #5 clk = ~clk;

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();

    assign bus0.s_tick   = s_tick;
    assign bus0.tx_start = tx_start;
    assign bus0.din      = din;
    assign bus1.s_tick   = s_tick;
    assign bus1.tx_start = tx_start;
    assign bus1.din      = din;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    logic tx_o [2];
    logic busy_o [2];
    logic done_o [2];
    assign tx_o[0]   = bus0.tx;
    assign tx_o[1]   = bus1.tx;
    assign busy_o[0] = bus0.tx_busy;
    assign busy_o[1] = bus1.tx_busy;
    assign done_o[0] = bus0.tx_done_tick;
    assign done_o[1] = bus1.tx_done_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    function automatic int p_dbit(input int i);
        return (i == 0) ? 8 : 7;
    endfunction
    function automatic int p_sbt(input int i);
        return (i == 0) ? 16 : 32;
    endfunction
    function automatic logic p_odd(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic int frame_len(input int i);
        return 16 * (1 + p_dbit(i) + PAR) + p_sbt(i);
    endfunction

    bit         m_busy [2];
    int         m_t    [2];
    logic [7:0] m_data [2];

    function automatic logic exp_parity(input int i);
        logic [7:0] mask;
        mask = 8'((1 << p_dbit(i)) - 1);
        return (^(m_data[i] & mask)) ^ p_odd(i);
    endfunction

    // Line level as a function of ticks elapsed since accept: segment 0 is the
    // start bit, segments 1..DBIT carry data LSB-first, then parity, then stop.
    function automatic logic exp_line(input int i);
        int seg;
        if (!m_busy[i]) return 1'b1;
        seg = m_t[i] / 16;
        if (seg == 0) return 1'b0;
        if (seg <= p_dbit(i)) return m_data[i][seg-1];
        if (PAR == 1 && seg == p_dbit(i) + 1) return exp_parity(i);
        return 1'b1;
    endfunction

    function automatic logic exp_done(input int i);
        return m_busy[i] && s_tick && (m_t[i] == frame_len(i) - 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0;
                m_t[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (s_tick) begin
                        if (m_t[i] == frame_len(i) - 1) m_busy[i] <= 1'b0;
                        else                            m_t[i]    <= m_t[i] + 1;
                    end
                end else if (tx_start) begin
                    m_busy[i] <= 1'b1;
                    m_t[i]    <= 0;
                    m_data[i] <= din;
                end
            end
        end
    end

    // Every-cycle comparison of both transmitters against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i),   tx_o[i],   exp_line(i));
            check($sformatf("busy%0d", i), busy_o[i], m_busy[i]);
            check($sformatf("done%0d", i), done_o[i], exp_done(i));
        end
        if (done_o[0]) frames0++;
    end

    // Tick generator: 1 = every clk, 4 = every 4th clk, 0 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            case (tick_mode)
                1:       s_tick = 1'b1;
                4:       s_tick = (tcnt % 4 == 0);
                default: s_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Pulses tx_start with data, then watches for up to window cycles. Line
    // samples are taken mid-bit at per/2 + per*j cycles after accept. An
    // optional second start (din FF) is injected at cycle inject_at.
    task automatic run_frame(input logic [7:0] data, input int per, input int window,
                             input int inject_at, input bit stop_on_done,
                             output logic [10:0] bits0, output logic [10:0] bits1,
                             output int done_cyc, output int pulses);
        din      = data;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        din      = 8'($urandom);
        bits0    = '0;
        bits1    = '0;
        done_cyc = -1;
        pulses   = 0;
        for (int k = 1; k <= window; k++) begin
            tx_start = (k == inject_at);
            if (k == inject_at) din = 8'hFF;
            for (int j = 0; j < 11; j++) begin
                if (k == per / 2 + per * j) begin
                    bits0[j] = tx_o[0];
                    bits1[j] = tx_o[1];
                end
            end
            if (done_o[0]) begin
                pulses++;
                if (done_cyc < 0) done_cyc = k;
                if (stop_on_done) begin
                    tx_start = 1'b0;
                    return;
                end
            end
            step();
        end
        tx_start = 1'b0;
    endtask

    logic [10:0] b0, b1;
    int          dc, np, f_before;
    logic [7:0]  rnd;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx",   tx_o[0],   1'b1);
        check("rst_busy", busy_o[0], 1'b0);
        check("rst_done", done_o[0], 1'b0);
        reset = 1'b1;
        step();
        step();

        // Basic frame, tick every clk.
        tick_mode = 1;
        step();
        run_frame(8'hA5, 16, 300, 0, 1'b0, b0, b1, dc, np);
        check("a5_start", b0[0], 1'b0);
        check("a5_data",  b0[8:1], 8'hA5);
`ifdef UART_TX_PARITY_EN
        check("a5_parity", b0[9], 1'b0);
        check("a5_stop",   b0[10], 1'b1);
`else
        check("a5_stop",   b0[9], 1'b1);
`endif
        check("a5_done_cycle", dc, LEN0);
        check("a5_pulses",     np, 1);
        check("a5_inst1_data", b1[7:1], 7'h25);

        // Slow ticks, mid-frame start ignored.
        tick_mode = 4;
        run_frame(8'h3C, 64, 1500, 64 * 4 + 32, 1'b0, b0, b1, dc, np);
        check("slow_start", b0[0], 1'b0);
        check("slow_data",  b0[8:1], 8'h3C);
        check("slow_pulses", np, 1);
        check("slow_done_range", (dc >= 4 * (LEN0 - 1) + 1 && dc <= 4 * LEN0), 1'b1);

        // Back-to-back: start during done is ignored, next cycle is accepted.
        tick_mode = 1;
        step();
        f_before = frames0;
        run_frame(8'h55, 16, 400, 0, 1'b1, b0, b1, dc, np);
        check("b2b_first_data", b0[8:1], 8'h55);
        check("b2b_first_done", dc, LEN0);
        din      = 8'h55;
        tx_start = 1'b1;
        check("b2b_done_now", done_o[0], 1'b1);
        step();
        check("b2b_idle_tx",   tx_o[0],   1'b1);
        check("b2b_idle_busy", busy_o[0], 1'b0);
        run_frame(8'h55, 16, 400, 0, 1'b1, b0, b1, dc, np);
        check("b2b_second_start", b0[0], 1'b0);
        check("b2b_second_data",  b0[8:1], 8'h55);
        check("b2b_second_done",  dc, LEN0);
        step();
        repeat (300) step();
        check("b2b_frames", frames0 - f_before, 2);

        // Reset in data bit 4 of 00.
        f_before = frames0;
        din      = 8'h00;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (16 * 5 + 8 - 1) step();
        check("rst_mid_pre_tx",   tx_o[0],   1'b0);
        check("rst_mid_pre_busy", busy_o[0], 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_tx",   tx_o[0],   1'b1);
        check("rst_mid_busy", busy_o[0], 1'b0);
        check("rst_mid_done", done_o[0], 1'b0);
        step();
        step();
        check("rst_mid_frames", frames0, f_before);
        reset = 1'b1;
        step();
        rnd = 8'($urandom);
        run_frame(rnd, 16, 400, 0, 1'b0, b0, b1, dc, np);
        check("post_rst_data",   b0[8:1], rnd);
        check("post_rst_pulses", np, 1);

`ifdef UART_TX_PARITY_EN
        // Parity: 07 has three ones.
        run_frame(8'h07, 16, 300, 0, 1'b0, b0, b1, dc, np);
        check("par_even_bit",  b0[9], 1'b1);
        check("par_done",      dc, 176);
        check("par_odd_bit",   b1[8], 1'b0);
        check("par_inst1_data", b1[7:1], 7'h07);
`endif

        // Randomized traffic with mixed tick rates.
        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 2))
                0:       tick_mode = 0;
                1:       tick_mode = 1;
                default: tick_mode = 4;
            endcase
            repeat (4000) begin
                tx_start = ($urandom_range(0, 15) == 0);
                din      = 8'($urandom);
                step();
            end
        end
        tx_start  = 1'b0;
        tick_mode = 1;
        repeat (400) step();
        check("end_idle0", busy_o[0], 1'b0);
        check("end_idle1", busy_o[1], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
